encode_8to3_stream: RTL

ENCODE_8TO3_STREAM -- requirements
Module: encode_8to3_stream

---
 rtl/encode_8to3_stream.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/encode_8to3_stream.sv
// encode_8to3_stream
//   Streaming 8-to-3 priority encoder with a one-entry valid/ready output
//   register. An accepted word is encoded (bit 7 highest priority) and held
//   until the consumer takes it. Back-to-back throughput is one word per cycle
//   while out_ready is high.
//
// Optional feature macro: ENCODE_MULTIHOT_CHECK_EN
//   defined   -> multi is captured as 1 when the accepted word has two or
//                more bits set
//   undefined -> multi is tied to 0 and no multi-hot detection logic is built
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   encoder enable; 0 blocks new input acceptance
//   x[7:0]     in   word to encode
//   in_valid   in   x is valid this cycle
//   in_ready   out  block accepts x this cycle (combinational)
//   y[2:0]     out  index of the highest set bit of the held word
//   zero       out  held word was all zeros
//   multi      out  held word had more than one bit set
//   out_valid  out  y/zero/multi hold a result
//   out_ready  in   consumer takes the result this cycle
//   count      out  accepted-input counter, wraps modulo 2^CNT_W
module encode_8to3_stream #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       x,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       y,
  output logic             zero,
  output logic             multi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 3;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic           xfer;
  logic [Y_W-1:0] enc_y;
  logic           enc_zero;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an accept while FULL implies out_ready, so a
  // simultaneous transfer keeps the buffer FULL with the new result
  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (xfer && !accept) begin
          state_nxt = S_EMPTY;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Handshake outputs; in_ready never looks at in_valid
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_EMPTY: begin
        in_ready  = en;
      end
      S_FULL: begin
        in_ready  = en && out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
    if (rst) begin
      in_ready = 1'b0;
    end
  end

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  // Priority encoder: ascending scan so the highest set bit wins
  always_comb begin
    enc_y = '0;
    for (int i = 0; i < X_W; i++) begin
      if (x[i]) begin
        enc_y = Y_W'(i);
      end
    end
  end

  assign enc_zero = (x == '0);

  // Result and counter registers update only on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      zero  <= 1'b0;
      count <= '0;
    end else if (accept) begin
      y     <= enc_y;
      zero  <= enc_zero;
      count <= count + CNT_W'(1);
    end
  end

`ifdef ENCODE_MULTIHOT_CHECK_EN
  logic enc_multi;

  // Clearing the lowest set bit leaves a nonzero word iff two or more were set
  assign enc_multi = ((x & (x - X_W'(1))) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      multi <= 1'b0;
    end else if (accept) begin
      multi <= enc_multi;
    end
  end
`else
  assign multi = 1'b0;
`endif

endmodule
